// File: rtl/tawas_lsu.sv
// tawas_lsu: pointer+offset load/store unit with wait states, timeout and traps; TAWAS_LSU_ALIGN_CHECK_EN traps misaligned accesses
module tawas_lsu #(
    parameter int ADDR_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LS_OP_VLD,
    output logic                  LS_OP_RDY,
    input  logic [10+2*SEL_W-1:0] LS_OP,
    output logic [SEL_W-1:0]      LS_PTR_SEL,
    input  logic [ADDR_W-1:0]     LS_PTR,
    output logic [SEL_W-1:0]      LS_STORE_SEL,
    input  logic [31:0]           LS_STORE,
    output logic [ADDR_W-1:0]     DADDR,
    output logic                  DCS,
    output logic                  DWR,
    output logic [3:0]            DMASK,
    output logic [31:0]           DOUT,
    input  logic [31:0]           DIN,
    input  logic                  DREADY,
    output logic                  LS_PTR_UPD_VLD,
    output logic [SEL_W-1:0]      LS_PTR_UPD_SEL,
    output logic [ADDR_W-1:0]     LS_PTR_UPD,
    output logic                  LS_LOAD_VLD,
    output logic [SEL_W-1:0]      LS_LOAD_SEL,
    output logic [31:0]           LS_LOAD,
    output logic                  LS_ERR,
    output logic [ADDR_W-1:0]     LS_ERR_ADDR
);
    localparam int OW = 10 + 2*SEL_W;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic {IDLE, BUS} state_t;
    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic op_st, op_upd, op_sx;
    logic [1:0] op_sz;
    logic [4:0] op_off;
    logic [ADDR_W-1:0] off_ext, new_ptr, addr;
    logic legal, done, tmo, rdy, acc, issue;
    logic [3:0] mask;
    logic [31:0] wdata, lane, ext;
    logic [1:0] lo, lo_r, sz_r;
    logic sx_r, upd_r;
    logic [SEL_W-1:0] dsel_r, psel_r;
    logic [ADDR_W-1:0] nptr_r;
    assign op_st        = LS_OP[OW-1];
    assign op_upd       = LS_OP[OW-2];
    assign op_sz        = LS_OP[OW-3:OW-4];
    assign op_sx        = LS_OP[OW-5];
    assign op_off       = LS_OP[OW-6:2*SEL_W];
    assign LS_PTR_SEL   = LS_OP[2*SEL_W-1:SEL_W];
    assign LS_STORE_SEL = LS_OP[SEL_W-1:0];
    assign DCS            = state == BUS;
    assign LS_OP_RDY      = rdy;
    assign LS_PTR_UPD_VLD = done & upd_r & ~RST;
    assign LS_PTR_UPD_SEL = psel_r;
    assign LS_PTR_UPD     = nptr_r;
    always_comb begin
        off_ext = {{(ADDR_W-5){op_upd & op_off[4]}}, op_off};
        new_ptr = LS_PTR + (off_ext << op_sz);
        addr    = (op_upd & ~op_off[4]) ? LS_PTR : new_ptr;
`ifdef TAWAS_LSU_ALIGN_CHECK_EN
        legal = (op_sz != 2'd3) & ~(op_sz == 2'd1 & addr[0]) & ~(op_sz == 2'd2 & addr[1:0] != 2'd0);
`else
        legal = op_sz != 2'd3;
`endif
        done    = (state == BUS) & DREADY;
        tmo     = (TIMEOUT != 0) & (state == BUS) & ~DREADY & (tcnt == TW'(TIMEOUT));
        rdy     = (state == IDLE) | done;
        acc     = LS_OP_VLD & rdy;
        issue   = acc & legal;
        state_n = issue ? BUS : (done | tmo) ? IDLE : state;
        lo      = op_sz == 2'd0 ? addr[1:0] : op_sz == 2'd1 ? {addr[1], 1'b0} : 2'd0;
        mask    = op_sz == 2'd0 ? 4'b0001 << addr[1:0] : op_sz == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata   = op_sz == 2'd0 ? {4{LS_STORE[7:0]}} : op_sz == 2'd1 ? {2{LS_STORE[15:0]}} : LS_STORE;
        lane    = DIN >> {lo_r, 3'b000};
        ext     = sz_r == 2'd0 ? {{24{sx_r & lane[7]}}, lane[7:0]} :
                  sz_r == 2'd1 ? {{16{sx_r & lane[15]}}, lane[15:0]} : DIN;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            tcnt        <= '0;
            DADDR       <= '0;
            DWR         <= 1'b0;
            DMASK       <= 4'd0;
            DOUT        <= 32'd0;
            lo_r        <= 2'd0;
            sz_r        <= 2'd0;
            sx_r        <= 1'b0;
            upd_r       <= 1'b0;
            dsel_r      <= '0;
            psel_r      <= '0;
            nptr_r      <= '0;
            LS_LOAD_VLD <= 1'b0;
            LS_LOAD_SEL <= '0;
            LS_LOAD     <= 32'd0;
            LS_ERR      <= 1'b0;
            LS_ERR_ADDR <= '0;
        end else begin
            state <= state_n;
            tcnt  <= acc ? '0 : (state == BUS & ~DREADY) ? tcnt + TW'(1) : tcnt;
            if (issue) begin
                DADDR  <= {addr[ADDR_W-1:2], 2'b00};
                DWR    <= op_st;
                DMASK  <= mask;
                DOUT   <= wdata;
                lo_r   <= lo;
                sz_r   <= op_sz;
                sx_r   <= op_sx;
                upd_r  <= op_upd;
                dsel_r <= LS_STORE_SEL;
                psel_r <= LS_PTR_SEL;
                nptr_r <= new_ptr;
            end
            LS_LOAD_VLD <= done & ~DWR;
            if (done & ~DWR) begin
                LS_LOAD     <= ext;
                LS_LOAD_SEL <= dsel_r;
            end
            LS_ERR <= tmo | (acc & ~legal);
            if (tmo)
                LS_ERR_ADDR <= DADDR;
            else if (acc & ~legal)
                LS_ERR_ADDR <= addr;
        end
    end
endmodule

// File: tb/tb_tawas_lsu.sv
// tb_tawas_lsu: randomized and directed checks of tawas_lsu against an arithmetic reference model
module tb_tawas_lsu;
    localparam int TMO = 4;
    logic CLK = 0, RST = 1, LS_OP_VLD = 0, DREADY = 0;
    logic [15:0] LS_OP = '0;
    logic [31:0] LS_PTR = '0, LS_STORE = '0, DIN = '0;
    logic LS_OP_RDY, DCS, DWR, LS_PTR_UPD_VLD, LS_LOAD_VLD, LS_ERR;
    logic [2:0] LS_PTR_SEL, LS_STORE_SEL, LS_PTR_UPD_SEL, LS_LOAD_SEL;
    logic [31:0] DADDR, DOUT, LS_PTR_UPD, LS_LOAD, LS_ERR_ADDR;
    logic [3:0] DMASK;
    int n_checks = 0, n_fail = 0;

    tawas_lsu #(.ADDR_W(32), .SEL_W(3), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .LS_OP_VLD(LS_OP_VLD), .LS_OP_RDY(LS_OP_RDY), .LS_OP(LS_OP),
        .LS_PTR_SEL(LS_PTR_SEL), .LS_PTR(LS_PTR), .LS_STORE_SEL(LS_STORE_SEL), .LS_STORE(LS_STORE),
        .DADDR(DADDR), .DCS(DCS), .DWR(DWR), .DMASK(DMASK), .DOUT(DOUT), .DIN(DIN), .DREADY(DREADY),
        .LS_PTR_UPD_VLD(LS_PTR_UPD_VLD), .LS_PTR_UPD_SEL(LS_PTR_UPD_SEL), .LS_PTR_UPD(LS_PTR_UPD),
        .LS_LOAD_VLD(LS_LOAD_VLD), .LS_LOAD_SEL(LS_LOAD_SEL), .LS_LOAD(LS_LOAD),
        .LS_ERR(LS_ERR), .LS_ERR_ADDR(LS_ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_access(input logic st, input logic upd, input logic [1:0] size, input logic sx,
                              input logic [4:0] off, input logic [2:0] psel, input logic [2:0] dsel,
                              input logic [31:0] ptr, input logic [31:0] sdat, input logic [31:0] din,
                              input int waits);
        int scale, o, a4, lane_off;
        logic [31:0] nptr, addr, edout, eload;
        logic [3:0] emask;
        longint v;
        scale = 1 << size;
        o = (upd && off[4]) ? int'(off) - 32 : int'(off);
        nptr = ptr + 32'(o * scale);
        addr = (upd && o >= 0) ? ptr : nptr;
        a4 = int'(addr % 32'd4);
        emask = size == 0 ? 4'(1 << a4) : size == 1 ? 4'(3 << (2 * (a4 / 2))) : 4'hF;
        edout = size == 0 ? 32'(sdat[7:0]) * 32'h01010101 : size == 1 ? 32'(sdat[15:0]) * 32'h00010001 : sdat;
        lane_off = a4 - a4 % scale;
        v = (longint'(din) >> (8 * lane_off)) & ((longint'(1) << (8 * scale)) - 1);
        if (sx && size != 2 && v >= (longint'(1) << (8 * scale - 1))) v = v - (longint'(1) << (8 * scale));
        eload = v[31:0];
        LS_OP_VLD = 1; LS_OP = {st, upd, size, sx, off, psel, dsel}; LS_PTR = ptr; LS_STORE = sdat; DREADY = 0;
        #2;
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL acc_rdy got %b exp 1", LS_OP_RDY); end
        n_checks++; if ({LS_PTR_SEL, LS_STORE_SEL} !== {psel, dsel}) begin n_fail++; $display("FAIL sel_fields got %h exp %h", {LS_PTR_SEL, LS_STORE_SEL}, {psel, dsel}); end
        tick();
        LS_OP_VLD = 0; LS_PTR = $urandom; LS_STORE = $urandom;
        for (int w = 0; w <= waits; w++) begin
            DREADY = (w == waits); DIN = (w == waits) ? din : $urandom;
            #2;
            n_checks++; if ({DCS, DWR, DADDR, DMASK} !== {1'b1, st, addr & 32'hFFFFFFFC, emask}) begin n_fail++; $display("FAIL bus_ctl got %b %b %h %b exp 1 %b %h %b", DCS, DWR, DADDR, DMASK, st, addr & 32'hFFFFFFFC, emask); end
            if (st) begin n_checks++; if (DOUT !== edout) begin n_fail++; $display("FAIL dout got %h exp %h", DOUT, edout); end end
            n_checks++; if (LS_OP_RDY !== (w == waits)) begin n_fail++; $display("FAIL wait_rdy got %b exp %b", LS_OP_RDY, w == waits); end
            n_checks++; if (LS_PTR_UPD_VLD !== (upd && w == waits)) begin n_fail++; $display("FAIL ptr_upd_vld got %b exp %b", LS_PTR_UPD_VLD, upd && w == waits); end
            if (upd && w == waits) begin n_checks++; if ({LS_PTR_UPD, LS_PTR_UPD_SEL} !== {nptr, psel}) begin n_fail++; $display("FAIL ptr_upd got %h/%0d exp %h/%0d", LS_PTR_UPD, LS_PTR_UPD_SEL, nptr, psel); end end
            tick();
        end
        DREADY = 0;
        #2;
        n_checks++; if ({DCS, LS_ERR, LS_PTR_UPD_VLD} !== 3'b000) begin n_fail++; $display("FAIL post_idle got %b exp 000", {DCS, LS_ERR, LS_PTR_UPD_VLD}); end
        n_checks++; if (LS_LOAD_VLD !== !st) begin n_fail++; $display("FAIL load_vld got %b exp %b", LS_LOAD_VLD, !st); end
        if (!st) begin n_checks++; if ({LS_LOAD, LS_LOAD_SEL} !== {eload, dsel}) begin n_fail++; $display("FAIL load got %h/%0d exp %h/%0d", LS_LOAD, LS_LOAD_SEL, eload, dsel); end end
        tick();
    endtask

    task automatic test_reset();
        RST = 1; tick(); tick();
        #2;
        n_checks++; if ({DCS, DWR, DMASK, DOUT, DADDR} !== '0) begin n_fail++; $display("FAIL reset_bus got %b %b %b %h %h exp 0", DCS, DWR, DMASK, DOUT, DADDR); end
        n_checks++; if ({LS_LOAD_VLD, LS_LOAD, LS_PTR_UPD_VLD, LS_PTR_UPD, LS_ERR, LS_ERR_ADDR} !== '0) begin n_fail++; $display("FAIL reset_wb got %b %h %b %h %b %h exp 0", LS_LOAD_VLD, LS_LOAD, LS_PTR_UPD_VLD, LS_PTR_UPD, LS_ERR, LS_ERR_ADDR); end
        RST = 0; tick();
        #2;
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b exp 1", LS_OP_RDY); end
        tick();
    endtask

    task automatic test_directed();
        run_access(0, 0, 2'd2, 0, 5'd3, 3'd1, 3'd2, 32'h1000, 32'h0, 32'hDEADBEEF, 0);
        run_access(1, 1, 2'd0, 0, 5'd1, 3'd3, 3'd4, 32'h2001, 32'h0000005A, 32'h0, 0);
        run_access(0, 1, 2'd1, 1, 5'h1F, 3'd5, 3'd6, 32'h3004, 32'h0, 32'h80010000, 0);
        run_access(0, 1, 2'd2, 0, 5'd1, 3'd7, 3'd0, 32'hFFFFFFFC, 32'h0, 32'h01234567, 1);
        run_access(0, 0, 2'd0, 1, 5'd2, 3'd1, 3'd1, 32'h40000001, 32'h0, 32'h00F20000, 2);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        logic [31:0] p;
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 2));
            p = $urandom;
`ifdef TAWAS_LSU_ALIGN_CHECK_EN
            p = p & ~(32'(1 << sz) - 32'd1);
`endif
            run_access(1'($urandom), 1'($urandom), sz, 1'($urandom), 5'($urandom), 3'($urandom), 3'($urandom),
                       p, $urandom, $urandom, int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back();
        LS_OP_VLD = 1; LS_OP = {1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 3'd2, 3'd1}; LS_PTR = 32'h4000;
        #2;
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL b2b_first_rdy got %b exp 1", LS_OP_RDY); end
        tick();
        LS_OP = {1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 3'd3, 3'd5}; LS_PTR = 32'h5003; LS_STORE = 32'h000000A5;
        for (int w = 0; w <= 3; w++) begin
            DREADY = (w == 3); DIN = (w == 3) ? 32'h11223344 : $urandom;
            #2;
            n_checks++; if ({DCS, DWR, DADDR, DMASK} !== {2'b10, 32'h4000, 4'hF}) begin n_fail++; $display("FAIL b2b_hold got %b %b %h %b exp 1 0 4000 1111", DCS, DWR, DADDR, DMASK); end
            n_checks++; if (LS_OP_RDY !== (w == 3)) begin n_fail++; $display("FAIL b2b_rdy got %b exp %b", LS_OP_RDY, w == 3); end
            tick();
        end
        LS_OP_VLD = 0; DREADY = 1;
        #2;
        n_checks++; if ({DCS, DWR, DADDR, DMASK, DOUT} !== {2'b11, 32'h5000, 4'b1000, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL b2b_second got %b %b %h %b %h exp 1 1 5000 1000 a5a5a5a5", DCS, DWR, DADDR, DMASK, DOUT); end
        n_checks++; if ({LS_LOAD_VLD, LS_LOAD, LS_LOAD_SEL} !== {1'b1, 32'h11223344, 3'd1}) begin n_fail++; $display("FAIL b2b_load got %b %h %0d exp 1 11223344 1", LS_LOAD_VLD, LS_LOAD, LS_LOAD_SEL); end
        tick();
        DREADY = 0;
        #2;
        n_checks++; if ({DCS, LS_LOAD_VLD} !== 2'b00) begin n_fail++; $display("FAIL b2b_end got %b exp 00", {DCS, LS_LOAD_VLD}); end
        tick();
    endtask

    task automatic test_timeout();
        int hi, errs, bad, err_cyc, low_cyc;
        logic [31:0] ea;
        hi = 0; errs = 0; bad = 0; err_cyc = -1; low_cyc = -1; ea = '0;
        LS_OP_VLD = 1; LS_OP = {1'b0, 1'b1, 2'd2, 1'b0, 5'd2, 3'd1, 3'd2}; LS_PTR = 32'h6000; DREADY = 0;
        tick();
        LS_OP_VLD = 0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (DCS) hi++; else if (low_cyc < 0) low_cyc = c;
            if (LS_ERR) begin errs++; err_cyc = c; ea = LS_ERR_ADDR; end
            if (LS_LOAD_VLD || LS_PTR_UPD_VLD) bad++;
            tick();
        end
        n_checks++; if (hi !== TMO + 1) begin n_fail++; $display("FAIL tmo_dcs_cycles got %0d exp %0d", hi, TMO + 1); end
        n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL tmo_err_pulses got %0d exp 1", errs); end
        n_checks++; if (err_cyc !== low_cyc) begin n_fail++; $display("FAIL tmo_err_timing got %0d exp %0d", err_cyc, low_cyc); end
        n_checks++; if (ea !== 32'h6000) begin n_fail++; $display("FAIL tmo_err_addr got %h exp 6000", ea); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tmo_writebacks got %0d exp 0", bad); end
        #2;
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL tmo_rdy got %b exp 1", LS_OP_RDY); end
        tick();
    endtask

    task automatic trap_case(input logic [15:0] op, input logic [31:0] ptr, input logic [31:0] eaddr);
        LS_OP_VLD = 1; LS_OP = op; LS_PTR = ptr;
        #2;
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL trap_rdy got %b exp 1", LS_OP_RDY); end
        tick();
        LS_OP_VLD = 0; DREADY = 1;
        #2;
        n_checks++; if ({DCS, LS_ERR, LS_ERR_ADDR} !== {2'b01, eaddr}) begin n_fail++; $display("FAIL trap_err got %b %b %h exp 0 1 %h", DCS, LS_ERR, LS_ERR_ADDR, eaddr); end
        n_checks++; if ({LS_PTR_UPD_VLD, LS_LOAD_VLD} !== 2'b00) begin n_fail++; $display("FAIL trap_wb got %b exp 00", {LS_PTR_UPD_VLD, LS_LOAD_VLD}); end
        tick();
        DREADY = 0;
        #2;
        n_checks++; if ({DCS, LS_ERR, LS_LOAD_VLD} !== 3'b000) begin n_fail++; $display("FAIL trap_after got %b exp 000", {DCS, LS_ERR, LS_LOAD_VLD}); end
        tick();
    endtask

    task automatic test_reserved();
        trap_case({1'b0, 1'b1, 2'd3, 1'b0, 5'd0, 3'd1, 3'd2}, 32'h7000, 32'h7000);
    endtask

    task automatic test_misaligned();
`ifdef TAWAS_LSU_ALIGN_CHECK_EN
        trap_case({1'b0, 1'b0, 2'd2, 1'b0, 5'd0, 3'd1, 3'd2}, 32'h1002, 32'h1002);
        trap_case({1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 3'd1, 3'd2}, 32'h1001, 32'h1001);
`else
        run_access(0, 0, 2'd2, 0, 5'd0, 3'd1, 3'd2, 32'h1002, 32'h0, 32'hCAFEF00D, 0);
        run_access(1, 0, 2'd1, 0, 5'd0, 3'd1, 3'd2, 32'h1001, 32'h0000BEEF, 32'h0, 0);
`endif
    endtask

    task automatic test_reset_mid();
        LS_OP_VLD = 1; LS_OP = {1'b0, 1'b1, 2'd2, 1'b0, 5'd1, 3'd1, 3'd2}; LS_PTR = 32'h8000;
        tick();
        LS_OP_VLD = 0; DREADY = 0;
        #2;
        n_checks++; if (DCS !== 1'b1) begin n_fail++; $display("FAIL rstmid_dcs got %b exp 1", DCS); end
        tick();
        RST = 1; DREADY = 1; DIN = 32'h12345678;
        #2;
        n_checks++; if (LS_PTR_UPD_VLD !== 1'b0) begin n_fail++; $display("FAIL rstmid_ptr_upd got %b exp 0", LS_PTR_UPD_VLD); end
        tick();
        RST = 0; DREADY = 0;
        #2;
        n_checks++; if ({DCS, DWR, DMASK, DOUT, DADDR, LS_LOAD_VLD, LS_LOAD, LS_ERR, LS_PTR_UPD_VLD} !== '0) begin n_fail++; $display("FAIL rstmid_outputs got %b %b %b %h %h %b %h %b %b exp 0", DCS, DWR, DMASK, DOUT, DADDR, LS_LOAD_VLD, LS_LOAD, LS_ERR, LS_PTR_UPD_VLD); end
        n_checks++; if (LS_OP_RDY !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy got %b exp 1", LS_OP_RDY); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_timeout();
        test_reserved();
        test_misaligned();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
